arb_mux4_ctrl: RTL

ARB_MUX4_CTRL -- requirements
Module: arb_mux4_ctrl

---
 rtl/arb_mux4_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/arb_mux4_ctrl.sv
// -----------------------------------------------------------------------------
// arb_mux4_ctrl
// Round-robin arbiter that steers an external 4:1 datapath mux and captures
// the selected word into a one-deep output register with valid/ready flow
// control. A new word may be captured every cycle (consume + capture at the
// same edge), so throughput is one word per clock.
//
// Ports
//   clk_i      in   1   system clock, all state on the rising edge
//   rst_i      in   1   synchronous active-low reset
//   req_i      in   4   per-requester request, bit n = requester n
//   gnt_o      out  4   one-hot grant, combinational; high = data captured now
//   select_o   out  2   select for the external mux (n routes requester n)
//   mux_data_i in  32   external mux output returned to this block
//   data_o     out 32   registered output word
//   valid_o    out  1   data_o holds an unconsumed word
//   ready_i    in   1   downstream accepts data_o when valid_o && ready_i
// -----------------------------------------------------------------------------
module arb_mux4_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  req_i,
    output logic [3:0]  gnt_o,
    output logic [1:0]  select_o,
    input  logic [31:0] mux_data_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  last_sel_q, last_sel_d;
    logic [1:0]  ptr_q, ptr_d;

    logic [1:0]  winner_s;
    logic        found_s;
    logic        load_s;

    // Round-robin search: first requester at or after ptr, wrapping mod 4.
    always_comb begin
        logic [1:0] idx_v;
        winner_s = 2'd0;
        found_s  = 1'b0;
        idx_v    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx_v = ptr_q + 2'(i);
            if (!found_s && req_i[idx_v]) begin
                winner_s = idx_v;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // A capture happens when the output slot is free or being drained this
    // cycle; gating with rst_i keeps grants quiet while reset is held.
    always_comb begin
        load_s = rst_i & ((state_q == ST_IDLE) | ready_i) & found_s;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        last_sel_d = last_sel_q;
        ptr_d      = ptr_q;
        if (load_s) begin
            state_d    = ST_BUSY;
            data_d     = mux_data_i;
            last_sel_d = winner_s;
            ptr_d      = winner_s + 2'd1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_BUSY: begin
                    if (ready_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            data_q     <= 32'd0;
            last_sel_q <= 2'd0;
            ptr_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            last_sel_q <= last_sel_d;
            ptr_q      <= ptr_d;
        end
    end

    // Grant/select outputs; select parks on the last winner when idle or
    // stalled so the external mux does not toggle needlessly.
    always_comb begin
        gnt_o    = 4'b0000;
        select_o = last_sel_q;
        if (!rst_i) begin
            select_o = 2'd0;
        end else if (load_s) begin
            gnt_o    = 4'b0001 << winner_s;
            select_o = winner_s;
        end else begin
            select_o = last_sel_q;
        end
    end

    assign data_o  = data_q;
    assign valid_o = (state_q == ST_BUSY);

endmodule
